// File: rtl/scpad_frontend_mc.sv
// Multi-channel scratchpad frontend: per-channel request FIFOs, round-robin issue, in-order response routing.
// Optional SCPAD_FE_BYPASS_EN: a request on an empty channel that wins arbitration drives the body port directly.
module scpad_frontend_mc #(
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 8,
    parameter int ADDR_W  = 20,
    parameter int COL_W   = 5,
    parameter int DATA_W  = 128
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic                     body_valid,
    input  logic                     body_stall,
    output logic                     body_write,
    output logic [ADDR_W-COL_W-1:0]  body_row,
    output logic [COL_W-1:0]         body_col,
    output logic [DATA_W-1:0]        body_wdata,
    input  logic                     body_res_valid,
    input  logic [DATA_W-1:0]        body_res_data,
    output logic [NUM_CH-1:0]        res_valid,
    output logic [DATA_W-1:0]        res_data,
    output logic                     err
);
    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT);

    logic              q_write [NUM_CH][DEPTH];
    logic [ADDR_W-1:0] q_addr  [NUM_CH][DEPTH];
    logic [DATA_W-1:0] q_data  [NUM_CH][DEPTH];
    logic [PW-1:0]     wptr    [NUM_CH];
    logic [PW-1:0]     rptr    [NUM_CH];
    logic [PW:0]       count   [NUM_CH];

    logic [NUM_CH-1:0] full, nonempty, cand, push, pop;
    logic [CW-1:0]     rr_ptr, grant, lock_ch;
    logic              locked, found, bypass, issue, res_pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    int                k;

    logic [CW-1:0]     oid [MAX_OUT];
    logic [OW-1:0]     owptr, orptr;
    logic [OW:0]       out_count;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]     = count[c] == (PW+1)'(DEPTH);
            nonempty[c] = count[c] != '0;
        end
`ifdef SCPAD_FE_BYPASS_EN
        cand = nonempty | req_valid;
`else
        cand = nonempty;
`endif
        grant = rr_ptr;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (!found && cand[k[CW-1:0]]) begin
                found = 1'b1;
                grant = k[CW-1:0];
            end
        end
        // A stalled grant is pinned so late arrivals cannot change body_*
        if (locked) begin
            found = 1'b1;
            grant = lock_ch;
        end
`ifdef SCPAD_FE_BYPASS_EN
        bypass = found && !nonempty[grant];
`else
        bypass = 1'b0;
`endif
        if (bypass) begin
            head_write = req_write[grant];
            head_addr  = req_addr[grant*ADDR_W +: ADDR_W];
            head_data  = req_wdata[grant*DATA_W +: DATA_W];
        end else begin
            head_write = q_write[grant][rptr[grant]];
            head_addr  = q_addr[grant][rptr[grant]];
            head_data  = q_data[grant][rptr[grant]];
        end
        body_valid = found && (out_count < (OW+1)'(MAX_OUT));
        issue      = body_valid && !body_stall;
        for (int c = 0; c < NUM_CH; c++) begin
            push[c] = req_valid[c] && !full[c]
                      && !(bypass && issue && grant == CW'(c));
            pop[c]  = issue && !bypass && grant == CW'(c);
        end
        res_pop   = body_res_valid && out_count != '0;
        res_valid = '0;
        if (res_pop) res_valid[oid[orptr]] = 1'b1;
    end

    assign req_ready  = ~full;
    assign body_write = head_write;
    assign body_row   = head_addr[ADDR_W-1:COL_W];
    assign body_col   = head_addr[COL_W-1:0];
    assign body_wdata = head_data;
    assign res_data   = body_res_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c]  <= '0;
                rptr[c]  <= '0;
                count[c] <= '0;
            end
            rr_ptr    <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
            owptr     <= '0;
            orptr     <= '0;
            out_count <= '0;
            err       <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wptr[c] <= wptr[c] + 1'b1;
                if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
                if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
                else if (!push[c] && pop[c]) count[c] <= count[c] - 1'b1;
            end
            if (issue)
                rr_ptr <= (grant == CW'(NUM_CH-1)) ? '0 : grant + 1'b1;
            locked  <= body_valid && body_stall;
            lock_ch <= grant;
            if (issue)   owptr <= owptr + 1'b1;
            if (res_pop) orptr <= orptr + 1'b1;
            if (issue && !res_pop)      out_count <= out_count + 1'b1;
            else if (!issue && res_pop) out_count <= out_count - 1'b1;
            if (body_res_valid && out_count == '0) err <= 1'b1;
        end
    end

    // Storage arrays carry no reset; pointers and counts define validity
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                q_write[c][wptr[c]] <= req_write[c];
                q_addr[c][wptr[c]]  <= req_addr[c*ADDR_W +: ADDR_W];
                q_data[c][wptr[c]]  <= req_wdata[c*DATA_W +: DATA_W];
            end
        end
        if (issue) oid[owptr] <= grant;
    end

endmodule

// File: tb/tb_scpad_frontend_mc.sv
// Self-checking bench for scpad_frontend_mc: issue and response scoreboards.
// Expected issues/responses are queued at drive time and compared when the DUT produces them.
`timescale 1ns/1ps
module tb_scpad_frontend_mc;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 20;
    localparam int COL_W  = 5;
    localparam int DATA_W = 128;
    localparam int EW     = 1 + ADDR_W + DATA_W;

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic [NUM_CH-1:0]        req_valid, req_ready, req_write;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic                     body_valid, body_stall, body_write;
    logic [ADDR_W-COL_W-1:0]  body_row;
    logic [COL_W-1:0]         body_col;
    logic [DATA_W-1:0]        body_wdata;
    logic                     body_res_valid;
    logic [DATA_W-1:0]        body_res_data;
    logic [NUM_CH-1:0]        res_valid;
    logic [DATA_W-1:0]        res_data;
    logic                     err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0]            exp_iss[$];
    logic [NUM_CH+DATA_W-1:0] exp_res[$];
    logic [DATA_W-1:0]        first_d;

    scpad_frontend_mc dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .body_valid(body_valid), .body_stall(body_stall), .body_write(body_write),
        .body_row(body_row), .body_col(body_col), .body_wdata(body_wdata),
        .body_res_valid(body_res_valid), .body_res_data(body_res_data),
        .res_valid(res_valid), .res_data(res_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (body_valid && !body_stall) begin
                if (exp_iss.size() == 0) check("issue_unexp", 160'(body_valid), 160'(0));
                else check("issue", 160'({body_write, body_row, body_col, body_wdata}),
                           160'(exp_iss.pop_front()));
            end
            if (res_valid != '0) begin
                if (exp_res.size() == 0) check("res_unexp", 160'(res_valid), 160'(0));
                else check("res", 160'({res_valid, res_data}), 160'(exp_res.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid      = '0;
        body_stall     = 1'b0;
        body_res_valid = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        idle_inputs();
        exp_iss.delete();
        exp_res.delete();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic set_req(input int c, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[c] = 1'b1;
        req_write[c] = w;
        req_addr[c*ADDR_W +: ADDR_W]  = a;
        req_wdata[c*DATA_W +: DATA_W] = d;
        exp_iss.push_back({w, a, d});
    endtask

    task automatic drain(input string tag, input int budget);
        int b = budget;
        while (exp_iss.size() != 0 && b > 0) begin
            step();
            b--;
        end
        check(tag, 160'(exp_iss.size()), 160'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        body_res_data = '0;
        idle_inputs();

        // reset state and first-request latency
        do_reset();
        check("rst_ready", 160'(req_ready), 160'(4'hF));
        check("rst_bvalid", 160'(body_valid), 160'(0));
        check("rst_res", 160'(res_valid), 160'(0));
        check("rst_err", 160'(err), 160'(0));
        set_req(0, 1'b1, 20'h00043, 128'hA0);
        #1;
`ifdef SCPAD_FE_BYPASS_EN
        check("lat_now", 160'(body_valid), 160'(1));
        check("row", 160'(body_row), 160'(15'h2));
        check("col", 160'(body_col), 160'(5'h03));
        step();
        req_valid = '0;
`else
        check("lat_now", 160'(body_valid), 160'(0));
        step();
        req_valid = '0;
        #1;
        check("lat_next", 160'(body_valid), 160'(1));
        check("row", 160'(body_row), 160'(15'h2));
        check("col", 160'(body_col), 160'(5'h03));
`endif
        drain("drain_lat", 5);

        // all channels twice: round-robin 0,1,2,3,0,1,2,3
        do_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            req_valid = '0;
            if (cyc < 2)
                for (int c = 0; c < NUM_CH; c++)
                    set_req(c, 1'b0, 20'(16'h100 + 16 * cyc + c), 128'(1000 + 4 * cyc + c));
            #1 check("rr_ready", 160'(req_ready), 160'(4'hF));
        end
        drain("drain_rr", 4);

        // fill ch1 under stall, then stream out
        do_reset();
        body_stall = 1'b1;
        first_d = 128'h5000;
        for (int i = 0; i < 4; i++) begin
            step();
            req_valid = '0;
            set_req(1, i[0], 20'(32'h2000 + 32 * i), 128'(32'h5000 + i));
        end
        step();
        req_valid = '0;
        #1;
        check("full_ready", 160'(req_ready), 160'(4'b1101));
        check("stall_bvalid", 160'(body_valid), 160'(1));
        check("stall_data", 160'(body_wdata), 160'(first_d));
        step();
        check("stall_hold", 160'(body_wdata), 160'(first_d));
        body_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("stream", 160'(body_valid), 160'(1));
            step();
        end
        #1 check("stream_end", 160'(body_valid), 160'(0));
        check("drain_stream", 160'(exp_iss.size()), 160'(0));

        // outstanding limit
        do_reset();
        for (int r = 0; r < 2; r++) begin
            step();
            req_valid = '0;
            for (int c = 0; c < NUM_CH; c++)
                set_req(c, 1'b0, 20'(32'h300 + 4 * r + c), 128'(32'h7000 + 4 * r + c));
        end
        step();
        req_valid = '0;
        set_req(0, 1'b0, 20'h00399, 128'h7999);
        step();
        req_valid = '0;
        repeat (8) step();
        check("max_out_gate", 160'(body_valid), 160'(0));
        check("max_out_left", 160'(exp_iss.size()), 160'(1));
        body_res_valid = 1'b1;
        body_res_data  = 128'hBEEF;
        exp_res.push_back({4'b0001, 128'hBEEF});
        #1 check("free_same_cyc", 160'(body_valid), 160'(0));
        step();
        body_res_valid = 1'b0;
        #1 check("free_next_cyc", 160'(body_valid), 160'(1));
        step();
        check("max_out_drain", 160'(exp_iss.size()), 160'(0));

        // interleaved issue and routed responses
        do_reset();
        step();
        set_req(2, 1'b0, 20'h04444, 128'h22);
        step();
        req_valid = '0;
        set_req(0, 1'b0, 20'h04400, 128'h00);
        step();
        req_valid = '0;
        set_req(3, 1'b0, 20'h04433, 128'h33);
        step();
        req_valid = '0;
        drain("drain_il", 5);
        for (int i = 0; i < 3; i++) begin
            step();
            body_res_valid = 1'b1;
            body_res_data  = 128'(32'hD000 + i);
            case (i)
                0:       exp_res.push_back({4'b0100, 128'(32'hD000)});
                1:       exp_res.push_back({4'b0001, 128'(32'hD001)});
                default: exp_res.push_back({4'b1000, 128'(32'hD002)});
            endcase
        end
        step();
        body_res_valid = 1'b0;
        #1 check("res_drain", 160'(exp_res.size()), 160'(0));

        // spurious response sets sticky err
        step();
        body_res_valid = 1'b1;
        #1 check("spur_res", 160'(res_valid), 160'(0));
        check("err_pre", 160'(err), 160'(0));
        step();
        body_res_valid = 1'b0;
        #1 check("err_set", 160'(err), 160'(1));
        repeat (3) step();
        check("err_sticky", 160'(err), 160'(1));

        // reset mid-traffic
        body_stall = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            req_valid = '0;
            for (int c = 0; c < NUM_CH; c++)
                set_req(c, 1'b1, 20'(32'h500 + 4 * r + c), 128'(32'h9000 + 4 * r + c));
        end
        step();
        n_rst = 1'b0;
        idle_inputs();
        exp_iss.delete();
        exp_res.delete();
        #1;
        check("mrst_ready", 160'(req_ready), 160'(4'hF));
        check("mrst_bvalid", 160'(body_valid), 160'(0));
        check("mrst_err", 160'(err), 160'(0));
        repeat (2) step();
        n_rst = 1'b1;
        step();
        check("post_ready", 160'(req_ready), 160'(4'hF));
        check("post_bvalid", 160'(body_valid), 160'(0));
        body_res_valid = 1'b1;
        step();
        body_res_valid = 1'b0;
        #1 check("late_res_err", 160'(err), 160'(1));
        check("final_iss", 160'(exp_iss.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
